piccolo_ksched_ctrl: RTL and testbench

Sequential key-schedule controller for the Piccolo core. It latches a user key on a start pulse and emits the 64-bit whitening key. It then streams one round-key pair (rk2i||rk2i+1) per round over a valid/ready handshake, so the round datapath consumes keys on demand. The round constants con2i/con2i+1 come from an internal constant sub-module indexed by the round counter.

---
 rtl/piccolo_ksched_ctrl_pkg.sv | 40 ++++
 rtl/piccolo_con_gen.sv | 21 ++
 rtl/piccolo_ksched_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_piccolo_ksched_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piccolo_ksched_ctrl_pkg.sv
// Shared definitions for the Piccolo key-schedule controller: constants,
// state encoding, the half-word key type and small key helpers.
package piccolo_ksched_ctrl_pkg;

  localparam logic [31:0] KEYCONST      = 32'h0F1E2D3C;
  localparam int          ROUNDS80_DEF  = 25;
  localparam int          ROUNDS128_DEF = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  typedef logic [15:0] half_t;

  // Element n holds key word kn (k0 is element 0).
  typedef half_t [7:0] keyreg_t;

  // Whitening-key half built from the high byte of one word and the low byte of another.
  function automatic half_t mix_bytes(input half_t hi_src, input half_t lo_src);
    return {hi_src[15:8], lo_src[7:0]};
  endfunction

  // 128-bit schedule reordering (k2,k1,k6,k7,k0,k3,k4,k5).
  function automatic keyreg_t permute_key(input keyreg_t k);
    keyreg_t p;
    p[0] = k[2];
    p[1] = k[1];
    p[2] = k[6];
    p[3] = k[7];
    p[4] = k[0];
    p[5] = k[3];
    p[6] = k[4];
    p[7] = k[5];
    return p;
  endfunction

endpackage

// File: rtl/piccolo_con_gen.sv
// Round-constant generator: maps the round index to the con2i/con2i+1 pair.
module piccolo_con_gen
  import piccolo_ksched_ctrl_pkg::*;
(
  input  logic [4:0] i,
  output half_t      con_hi,
  output half_t      con_lo
);

  logic [4:0]  ci;
  logic [31:0] t;

  // Pack ci around zero fields into 32 bits, then fold in the fixed mask.
  always_comb begin
    ci     = i + 5'd1;
    t      = {ci, 5'd0, ci, 2'b00, ci, 5'd0, ci} ^ KEYCONST;
    con_hi = t[31:16];
    con_lo = t[15:0];
  end

endmodule

// File: rtl/piccolo_ksched_ctrl.sv
// Piccolo key-schedule controller: latches the user key, emits the whitening
// key and streams one round-key pair per round over valid/ready.
// Optional 128-bit key support is compiled in when PICCOLO_128_EN is defined.
module piccolo_ksched_ctrl
  import piccolo_ksched_ctrl_pkg::*;
#(
  parameter int ROUNDS80  = ROUNDS80_DEF,
  parameter int ROUNDS128 = ROUNDS128_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_len,
  output logic         busy,
  output logic         wk_valid,
  output logic [63:0]  wk_out,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [31:0]  rk_out,
  output logic [4:0]   rk_round,
  output logic         rk_last,
  output logic         done
);

  localparam logic [4:0] LAST80 = 5'(ROUNDS80 - 1);

  state_t      state_q, state_d;
  keyreg_t     key_q, load_key, pair_key;
  logic [4:0]  i_q, pair_i, last_idx;
  logic [2:0]  mod5_q, pair_mod5;
  logic        advance;
  logic [63:0] wk_q, wk_d;
  logic        wk_valid_q;
  logic [31:0] rk_q, rk_d;
  half_t       con_hi, con_lo;
  half_t       rk_hi, rk_lo;

`ifdef PICCOLO_128_EN
  localparam logic [4:0] LAST128 = 5'(ROUNDS128 - 1);
  logic       mode_q;
  logic [2:0] idx_hi, idx_lo;
`else
  localparam int unused_rounds128 = ROUNDS128;
  logic unused_inputs;
  assign unused_inputs = ^{key_len, key_in[127:80]};
`endif

  piccolo_con_gen u_con_gen (
    .i      (pair_i),
    .con_hi (con_hi),
    .con_lo (con_lo)
  );

  // Final round index for the mode latched with start.
  always_comb begin
    last_idx = LAST80;
`ifdef PICCOLO_128_EN
    if (mode_q) last_idx = LAST128;
`endif
  end

  // Split the user key into 16-bit words, k0 being the most significant word.
  always_comb begin
    load_key = '0;
    for (int n = 0; n < 5; n++) load_key[n] = key_in[79-16*n -: 16];
`ifdef PICCOLO_128_EN
    if (key_len) begin
      for (int n = 0; n < 8; n++) load_key[n] = key_in[127-16*n -: 16];
    end
`endif
  end

  // Next-state logic, status outputs and selection of the next pair to present.
  always_comb begin
    state_d   = state_q;
    advance   = 1'b0;
    pair_i    = i_q;
    pair_mod5 = mod5_q;
    pair_key  = key_q;
    busy      = (state_q != ST_IDLE);
    rk_valid  = (state_q == ST_RUN);
    done      = (state_q == ST_FIN);
    rk_last   = (state_q == ST_RUN) && (i_q == last_idx);
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d   = ST_RUN;
        advance   = 1'b1;
        pair_i    = 5'd0;
        pair_mod5 = 3'd0;
      end
      ST_RUN: begin
        if (rk_ready) begin
          if (i_q == last_idx) begin
            state_d = ST_FIN;
          end else begin
            advance   = 1'b1;
            pair_i    = i_q + 5'd1;
            pair_mod5 = (mod5_q == 3'd4) ? 3'd0 : mod5_q + 3'd1;
`ifdef PICCOLO_128_EN
            if (mode_q && (pair_i[1:0] == 2'b11)) pair_key = permute_key(key_q);
`endif
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pick the two key words for the next pair and mix in the round constants.
  always_comb begin
    rk_hi = pair_key[2];
    rk_lo = pair_key[3];
    case (pair_mod5)
      3'd1, 3'd4: begin
        rk_hi = pair_key[0];
        rk_lo = pair_key[1];
      end
      3'd3: begin
        rk_hi = pair_key[4];
        rk_lo = pair_key[4];
      end
      default: ;
    endcase
`ifdef PICCOLO_128_EN
    idx_hi = {pair_i[1:0] + 2'd1, 1'b0};
    idx_lo = {pair_i[1:0] + 2'd1, 1'b1};
    if (mode_q) begin
      rk_hi = pair_key[idx_hi];
      rk_lo = pair_key[idx_lo];
    end
`endif
    rk_d = {rk_hi ^ con_hi, rk_lo ^ con_lo};
  end

  // Whitening key from the latched key words.
  always_comb begin
    wk_d = {mix_bytes(key_q[0], key_q[1]), mix_bytes(key_q[1], key_q[0]),
            mix_bytes(key_q[4], key_q[3]), mix_bytes(key_q[3], key_q[4])};
`ifdef PICCOLO_128_EN
    if (mode_q) wk_d[31:0] = {mix_bytes(key_q[4], key_q[7]), mix_bytes(key_q[7], key_q[4])};
`endif
  end

  // State, key register, round counters and registered key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      i_q        <= '0;
      mod5_q     <= '0;
      wk_q       <= '0;
      wk_valid_q <= 1'b0;
      rk_q       <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start) begin
        key_q      <= load_key;
        wk_valid_q <= 1'b0;
      end
      if (state_q == ST_LOAD) begin
        wk_q       <= wk_d;
        wk_valid_q <= 1'b1;
      end
      if (advance) begin
        i_q    <= pair_i;
        mod5_q <= pair_mod5;
        key_q  <= pair_key;
        rk_q   <= rk_d;
      end
    end
  end

`ifdef PICCOLO_128_EN
  // Key-length mode captured alongside the key.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && start) begin
      mode_q <= key_len;
    end
  end
`endif

  assign wk_valid = wk_valid_q;
  assign wk_out   = wk_q;
  assign rk_out   = rk_q;
  assign rk_round = i_q;

endmodule

// File: tb/tb_piccolo_ksched_ctrl.sv
// Self-checking bench for piccolo_ksched_ctrl: a constant vector table, hand
// sequences for stall/abort/ignored-start, and randomized runs against a
// behavioural key-schedule model. Honours PICCOLO_128_EN like the design.
module tb_piccolo_ksched_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         key_len;
  logic         busy;
  logic         wk_valid;
  logic [63:0]  wk_out;
  logic         rk_valid;
  logic         rk_ready;
  logic [31:0]  rk_out;
  logic [4:0]   rk_round;
  logic         rk_last;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_pairs [32];
  logic [63:0] exp_wk;
  int          exp_rounds;

  typedef struct {
    logic [127:0] key;
    logic         len;
    logic [63:0]  wk;
    logic [31:0]  rk0;
    logic [31:0]  rk3;
  } vec_t;

  vec_t vecs [$];

  piccolo_ksched_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .key_len  (key_len),
    .busy     (busy),
    .wk_valid (wk_valid),
    .wk_out   (wk_out),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .rk_last  (rk_last),
    .done     (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] con_of(input int j);
    logic [31:0] c;
    c = 32'(j + 1);
    return ((c << 27) | (c << 17) | (c << 10) | c) ^ 32'h0F1E2D3C;
  endfunction

  // Expected whitening key and full pair sequence for one key.
  task automatic build_model(input logic [127:0] key, input logic len);
    logic [15:0] k [8];
    logic [15:0] t [8];
    logic [31:0] c;
    logic        eff_len;
`ifdef PICCOLO_128_EN
    eff_len = len;
`else
    eff_len = 1'b0;
`endif
    for (int n = 0; n < 8; n++) k[n] = 16'h0;
    if (eff_len) begin
      for (int n = 0; n < 8; n++) k[n] = key[127-16*n -: 16];
    end else begin
      for (int n = 0; n < 5; n++) k[n] = key[79-16*n -: 16];
    end
    exp_rounds = eff_len ? 31 : 25;
    if (eff_len)
      exp_wk = {k[0][15:8], k[1][7:0], k[1][15:8], k[0][7:0],
                k[4][15:8], k[7][7:0], k[7][15:8], k[4][7:0]};
    else
      exp_wk = {k[0][15:8], k[1][7:0], k[1][15:8], k[0][7:0],
                k[4][15:8], k[3][7:0], k[3][15:8], k[4][7:0]};
    for (int j = 0; j < exp_rounds; j++) begin
      c = con_of(j);
      if (eff_len) begin
        if (j % 4 == 3) begin
          t = k;
          k[0] = t[2]; k[1] = t[1]; k[2] = t[6]; k[3] = t[7];
          k[4] = t[0]; k[5] = t[3]; k[6] = t[4]; k[7] = t[5];
        end
        exp_pairs[j] = {k[(2*j+2)%8] ^ c[31:16], k[(2*j+3)%8] ^ c[15:0]};
      end else begin
        case (j % 5)
          0, 2:    exp_pairs[j] = {k[2] ^ c[31:16], k[3] ^ c[15:0]};
          1, 4:    exp_pairs[j] = {k[0] ^ c[31:16], k[1] ^ c[15:0]};
          default: exp_pairs[j] = {k[4] ^ c[31:16], k[4] ^ c[15:0]};
        endcase
      end
    end
  endtask

  // One run: start, then consume pairs with the given ready probability,
  // optional 5-cycle stall at stall_at, optional early exit at abort_at and an
  // optional ignored start pulse in the middle of the run.
  task automatic applyStimulus(input logic [127:0] key, input logic len, input int ready_pct,
                               input int stall_at, input int abort_at, input bit poke_start,
                               output logic [63:0] wk_seen, output logic [31:0] rk0_seen,
                               output logic [31:0] rk3_seen);
    int idx       = 0;
    int cycles    = 0;
    int stall_cnt = 0;
    bit pending   = 0;
    bit finished  = 0;
    bit poked     = 0;
    build_model(key, len);
    wk_seen  = '0;
    rk0_seen = '0;
    rk3_seen = '0;
    key_in   = key;
    key_len  = len;
    rk_ready = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("rk_valid_in_load", rk_valid, 0);
    checkOutput("wk_valid_cleared", wk_valid, 0);
    while (!finished && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      start   = 1'b0;
      key_in  = key;
      key_len = len;
      if (pending) idx++;
      pending = 0;
      if (idx == exp_rounds) begin
        checkOutput("done_pulse", done, 1);
        checkOutput("rk_valid_in_fin", rk_valid, 0);
        rk_ready = 1'b0;
        finished = 1;
      end else begin
        checkOutput("rk_valid", rk_valid, 1);
        checkOutput("done_early", done, 0);
        checkOutput("wk_valid", wk_valid, 1);
        checkOutput("wk_out", wk_out, exp_wk);
        checkOutput("rk_out", rk_out, exp_pairs[idx]);
        checkOutput("rk_round", rk_round, idx);
        checkOutput("rk_last", rk_last, idx == exp_rounds - 1);
        wk_seen = wk_out;
        if (idx == 0) rk0_seen = rk_out;
        if (idx == 3) rk3_seen = rk_out;
        if (idx == abort_at) begin
          rk_ready = 1'b0;
          return;
        end
        rk_ready = ($urandom_range(99) < ready_pct);
        if (idx == stall_at && stall_cnt < 5) begin
          rk_ready = 1'b0;
          stall_cnt++;
        end
        if (poke_start && !poked && idx == 5) begin
          start   = 1'b1;
          key_in  = ~key;
          key_len = ~len;
          poked   = 1;
        end
        pending = rk_valid && rk_ready;
      end
    end
    if (!finished) begin
      checkOutput("handshakes_before_timeout", idx, exp_rounds);
    end else begin
      @(posedge clk); #1;
      checkOutput("done_one_cycle", done, 0);
      checkOutput("busy_idle", busy, 0);
      checkOutput("rk_valid_idle", rk_valid, 0);
      checkOutput("wk_valid_hold", wk_valid, 1);
      checkOutput("wk_hold", wk_out, exp_wk);
    end
  endtask

  // Reset checks, vector table, corner-case sequences, then random runs.
  initial begin
    logic [63:0]  wk_s;
    logic [31:0]  r0, r3;
    logic [127:0] rkey;
    logic [127:0] key_a;
    key_a    = 128'h00112233445566778899;
    rst      = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    key_len  = 1'b0;
    rk_ready = 1'b0;

    vecs.push_back('{128'h00112233445566778899, 1'b0, 64'h0033221188776699, 32'h43494F4A, 32'hA78FB5A1});
    vecs.push_back('{128'h0, 1'b0, 64'h0, 32'h071C293D, 32'h2F163D38});
    vecs.push_back('{{128{1'b1}}, 1'b0, 64'hFFFFFFFFFFFFFFFF, 32'hF8E3D6C2, 32'hD0E9C2C7});
    vecs.push_back('{128'h0123456789ABCDEF0011, 1'b0, 64'h0167452300EFCD11, 32'h8EB7E4D2, 32'h2F073D29});
`ifdef PICCOLO_128_EN
    vecs.push_back('{128'h00112233445566778899AABBCCDDEEFF, 1'b1, 64'h0033221188FFEE99, 32'h43494F4A, 32'h6B431F0B});
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wk_valid", wk_valid, 0);
    checkOutput("reset_rk_valid", rk_valid, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_rk_out", rk_out, 0);
    checkOutput("reset_wk_out", wk_out, 0);
    checkOutput("reset_rk_round", rk_round, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].key, vecs[n].len, 100, -1, -1, 0, wk_s, r0, r3);
      checkOutput("tbl_wk", wk_s, vecs[n].wk);
      checkOutput("tbl_rk0", r0, vecs[n].rk0);
      checkOutput("tbl_rk3", r3, vecs[n].rk3);
    end

    $display("[TB] backpressure at round 2");
    applyStimulus(key_a, 1'b0, 100, 2, -1, 0, wk_s, r0, r3);

    $display("[TB] start pulse during run");
    applyStimulus(key_a, 1'b0, 100, -1, -1, 1, wk_s, r0, r3);

    $display("[TB] reset at round 10");
    applyStimulus(key_a, 1'b0, 100, -1, 10, 0, wk_s, r0, r3);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_rk_valid", rk_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_wk_valid", wk_valid, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_rk_round", rk_round, 0);
    checkOutput("abort_rk_out", rk_out, 0);
    rst = 1'b0;
    applyStimulus(key_a, 1'b0, 100, -1, -1, 0, wk_s, r0, r3);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(rkey, 1'($urandom_range(1)), $urandom_range(90, 30), -1, -1,
                    1'($urandom_range(1)), wk_s, r0, r3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
